// File: rtl/eth_pkg.sv
// Shared states, header offsets and CRC-32 constants for the Ethernet receive frame parser.
package eth_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DST     = 3'd1;
  localparam logic [2:0] S_SRC     = 3'd2;
  localparam logic [2:0] S_TYPE    = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_DROP    = 3'd5;

  localparam logic [47:0] C_BRDCST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [10:0] C_DST_END  = 11'd5;
  localparam logic [10:0] C_SRC_END  = 11'd11;
  localparam logic [10:0] C_TYPE_END = 11'd13;
  localparam int          C_FCS_LEN  = 4;
  // One extra stage so the oldest byte is known to be payload, not FCS.
  localparam int          C_BUF_DEPTH = C_FCS_LEN + 1;

  localparam logic [31:0] C_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] C_CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] C_CRC_RESIDUE = 32'hDEBB_20E3;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ C_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_frame_if.sv
// Byte-stream input, payload stream output and header/status outputs of the receive frame parser.
interface eth_rx_frame_if;
  logic        rx_byte_vld;
  logic        rx_data_vld;
  logic [7:0]  rx_byte;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        hdr_vld;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic        frame_good;
  logic        frame_bad;
  logic        frame_drop;

  modport master (
    output rx_byte_vld, rx_data_vld, rx_byte,
    input  m_tdata, m_tvalid, m_tlast, m_tuser, hdr_vld, dst_mac, src_mac, ethertype,
    input  frame_good, frame_bad, frame_drop
  );

  modport slave (
    input  rx_byte_vld, rx_data_vld, rx_byte,
    output m_tdata, m_tvalid, m_tlast, m_tuser, hdr_vld, dst_mac, src_mac, ethertype,
    output frame_good, frame_bad, frame_drop
  );
endinterface

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 accumulator; result registered one cycle after each enabled byte.
module eth_crc32 import eth_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) crc <= C_CRC_INIT;
    else if (en)       crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/eth_rx_frame.sv
// Ethernet rx parser: MAC filter, header capture, FCS strip; payload beats 1 cycle after byte 5 later, no backpressure.
// ETH_RX_FCS_CHECK_EN adds CRC-32 residue checking into the frame error flag.
module eth_rx_frame import eth_pkg::*; #(
  parameter logic [47:0] P_MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int          P_MIN_LEN  = 64,
  parameter int          P_MAX_LEN  = 1518
) (
  input logic          rx_clk,
  input logic          rx_rst_n,
  eth_rx_frame_if.slave bus
);

  localparam logic [10:0] C_MIN  = 11'(P_MIN_LEN);
  localparam logic [10:0] C_MAX  = 11'(P_MAX_LEN);
  localparam logic [2:0]  C_FULL = 3'(C_BUF_DEPTH);

  logic [2:0]   state;
  logic [10:0]  cnt;
  logic         armed;
  logic         dvld_q;
  logic [103:0] hdr_sh;
  logic [39:0]  pbuf;
  logic [2:0]   fill;
  logic         fin_pend;
  logic         fin_err;
  logic         acc;
  logic         eof;
  logic         err;
  logic         crc_bad;
  logic [47:0]  dst_now;

  assign acc     = bus.rx_byte_vld & bus.rx_data_vld;
  assign eof     = dvld_q & ~bus.rx_data_vld;
  assign dst_now = {hdr_sh[39:0], bus.rx_byte};

`ifdef ETH_RX_FCS_CHECK_EN
  logic [31:0] crc;
  eth_crc32 u_crc (.clk(rx_clk), .rst_n(rx_rst_n), .clr(eof), .en(acc), .data(bus.rx_byte), .crc(crc));
  assign crc_bad = (crc != C_CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  assign err = (cnt < C_MIN) | crc_bad;

  // armed stays low after reset until the line goes idle, so a frame cut by reset is never re-parsed.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      armed          <= 1'b0;
      dvld_q         <= 1'b0;
      hdr_sh         <= '0;
      pbuf           <= '0;
      fill           <= '0;
      fin_pend       <= 1'b0;
      fin_err        <= 1'b0;
      bus.m_tdata    <= '0;
      bus.m_tvalid   <= 1'b0;
      bus.m_tlast    <= 1'b0;
      bus.m_tuser    <= 1'b0;
      bus.hdr_vld    <= 1'b0;
      bus.dst_mac    <= '0;
      bus.src_mac    <= '0;
      bus.ethertype  <= '0;
      bus.frame_good <= 1'b0;
      bus.frame_bad  <= 1'b0;
      bus.frame_drop <= 1'b0;
    end else begin
      dvld_q         <= bus.rx_data_vld;
      bus.m_tvalid   <= 1'b0;
      bus.m_tlast    <= 1'b0;
      bus.m_tuser    <= 1'b0;
      bus.hdr_vld    <= 1'b0;
      bus.frame_drop <= 1'b0;
      fin_pend       <= 1'b0;
      bus.frame_good <= fin_pend & ~fin_err;
      bus.frame_bad  <= fin_pend & fin_err;
      if (!bus.rx_data_vld) armed <= 1'b1;
      if (acc) hdr_sh <= {hdr_sh[95:0], bus.rx_byte};
      if (acc && (state != S_IDLE || armed) && cnt != '1) cnt <= cnt + 11'd1;

      if (eof) begin
        state <= S_IDLE;
        cnt   <= '0;
        fill  <= '0;
        if (state == S_DST || state == S_SRC || state == S_TYPE) begin
          fin_pend <= 1'b1;
          fin_err  <= 1'b1;
        end else if (state == S_PAYLOAD) begin
          fin_pend <= 1'b1;
          fin_err  <= err | (fill != C_FULL);
          if (fill == C_FULL) begin
            bus.m_tvalid <= 1'b1;
            bus.m_tlast  <= 1'b1;
            bus.m_tuser  <= err;
            bus.m_tdata  <= pbuf[39:32];
          end
        end
      end else if (acc) begin
        case (state)
          S_IDLE:  if (armed) state <= S_DST;
          S_DST: begin
            if (cnt == C_DST_END) begin
              if (dst_now == P_MAC_ADDR || dst_now == C_BRDCST) begin
                state <= S_SRC;
              end else begin
                state          <= S_DROP;
                bus.frame_drop <= 1'b1;
              end
            end
          end
          S_SRC:   if (cnt == C_SRC_END) state <= S_TYPE;
          S_TYPE: begin
            if (cnt == C_TYPE_END) begin
              state         <= S_PAYLOAD;
              bus.hdr_vld   <= 1'b1;
              bus.dst_mac   <= hdr_sh[103:56];
              bus.src_mac   <= hdr_sh[55:8];
              bus.ethertype <= {hdr_sh[7:0], bus.rx_byte};
            end
          end
          S_PAYLOAD: begin
            if (cnt == C_MAX) begin
              state        <= S_DROP;
              fill         <= '0;
              fin_pend     <= 1'b1;
              fin_err      <= 1'b1;
              bus.m_tvalid <= 1'b1;
              bus.m_tlast  <= 1'b1;
              bus.m_tuser  <= 1'b1;
              bus.m_tdata  <= pbuf[39:32];
            end else begin
              pbuf <= {pbuf[31:0], bus.rx_byte};
              if (fill == C_FULL) begin
                bus.m_tvalid <= 1'b1;
                bus.m_tdata  <= pbuf[39:32];
              end else begin
                fill <= fill + 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame.sv
// Frame-level vector table plus reset corner sequence; payload beats checked against a scoreboard queue.
module tb_eth_rx_frame;
  import eth_pkg::*;

`ifdef ETH_RX_FCS_CHECK_EN
  localparam bit FCS_ON = 1'b1;
`else
  localparam bit FCS_ON = 1'b0;
`endif

  localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BAD  = 48'h02_00_00_00_00_99;
  localparam logic [47:0] SRC  = 48'h02_11_22_33_44_55;
  localparam logic [15:0] TYPE = 16'h0800;

  typedef struct {
    logic [47:0] dst;
    int          len;
    int          flip;
    int          gap;
    int          n_beats;
    bit          hdr;
    bit          good;
    bit          bad;
    bit          drop;
    bit          tuser;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_rx_frame_if ifc ();
  eth_rx_frame dut (.rx_clk(clk), .rx_rst_n(rst_n), .bus(ifc));

  int n_cmp = 0;
  int n_err = 0;
  int cnt_hdr = 0, cnt_good = 0, cnt_bad = 0, cnt_drop = 0;
  logic [9:0]  sb_q [$];
  logic [7:0]  fb [0:1599];
  logic [47:0] exp_dst;
  vec_t        tv [12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {1'b0, ifc.m_tdata, ifc.m_tvalid, ifc.m_tlast, ifc.m_tuser, ifc.hdr_vld, ifc.dst_mac,
            ifc.src_mac, ifc.ethertype, ifc.frame_good, ifc.frame_bad, ifc.frame_drop};
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic vec_t mk(input logic [47:0] dst, input int len, input int flip, input int gap,
                              input int nb, input bit hdr, input bit good, input bit bad,
                              input bit drop, input bit tuser);
    vec_t v;
    v.dst = dst; v.len = len; v.flip = flip; v.gap = gap; v.n_beats = nb;
    v.hdr = hdr; v.good = good; v.bad = bad; v.drop = drop; v.tuser = tuser;
    return v;
  endfunction

  // Monitor: pop the scoreboard on each beat, check header on hdr_vld, count status pulses.
  always @(negedge clk) begin
    if (ifc.m_tvalid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", {118'd0, ifc.m_tdata, ifc.m_tlast, ifc.m_tuser}, 128'h3FF_0000);
      end else begin
        chk("beat", {118'd0, ifc.m_tdata, ifc.m_tlast, ifc.m_tuser}, {118'd0, sb_q.pop_front()});
      end
    end
    if (ifc.hdr_vld) begin
      cnt_hdr++;
      chk("hdr_fields", {16'd0, ifc.dst_mac, ifc.src_mac, ifc.ethertype}, {16'd0, exp_dst, SRC, TYPE});
    end
    if (ifc.frame_good) cnt_good++;
    if (ifc.frame_bad)  cnt_bad++;
    if (ifc.frame_drop) cnt_drop++;
  end

  task automatic build_frame(input vec_t v);
    logic [31:0] c;
    logic [111:0] hdr;
    hdr = {v.dst, SRC, TYPE};
    for (int i = 0; i < v.len; i++) begin
      if (i < 14) fb[i] = hdr[111 - 8*i -: 8];
      else        fb[i] = 8'(i - 14);
    end
    if (v.len >= 18) begin
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < v.len - 4; i++) c = crc_upd(c, fb[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) fb[v.len - 4 + k] = c[8*k +: 8];
    end
    if (v.flip >= 0) fb[v.flip] = fb[v.flip] ^ 8'h01;
  endtask

  task automatic drive_bytes(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      ifc.rx_data_vld = 1'b1;
      ifc.rx_byte_vld = 1'b1;
      ifc.rx_byte     = fb[i];
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        ifc.rx_byte_vld = 1'b0;
      end
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    ifc.rx_byte_vld = 1'b0;
    ifc.rx_data_vld = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int h0, g0, b0, d0;
    logic [47:0] held;
    v = tv[idx];
    build_frame(v);
    held = ifc.dst_mac;
    if (v.hdr) exp_dst = v.dst;
    for (int k = 0; k < v.n_beats; k++)
      sb_q.push_back({fb[14 + k], k == v.n_beats - 1, (k == v.n_beats - 1) && v.tuser});
    h0 = cnt_hdr; g0 = cnt_good; b0 = cnt_bad; d0 = cnt_drop;
    // Stray strobe while the line is idle must be ignored.
    @(negedge clk);
    ifc.rx_byte_vld = 1'b1;
    ifc.rx_byte     = 8'hAA;
    @(negedge clk);
    ifc.rx_byte_vld = 1'b0;
    drive_bytes(0, v.len - 1, v.gap);
    end_frame();
    chk($sformatf("v%0d_sb_empty", idx), 128'(sb_q.size()), 128'd0);
    chk($sformatf("v%0d_hdr", idx),  128'(cnt_hdr - h0),  128'(v.hdr));
    chk($sformatf("v%0d_good", idx), 128'(cnt_good - g0), 128'(v.good));
    chk($sformatf("v%0d_bad", idx),  128'(cnt_bad - b0),  128'(v.bad));
    chk($sformatf("v%0d_drop", idx), 128'(cnt_drop - d0), 128'(v.drop));
    chk($sformatf("v%0d_dst_hold", idx), 128'(ifc.dst_mac), 128'(v.hdr ? v.dst : held));
    sb_q.delete();
  endtask

  initial begin
    int b0, g0;
    //          dst          len   flip gap beats hdr good      bad      drop tuser
    tv[0]  = mk(MAC,         64,   -1,  0,  46,   1,  1,        0,       0,   0);
    tv[1]  = mk(C_BRDCST,    64,   -1,  1,  46,   1,  1,        0,       0,   0);
    tv[2]  = mk(BAD,         64,   -1,  0,  0,    0,  0,        0,       1,   0);
    tv[3]  = mk(MAC,         64,   24,  2,  46,   1,  !FCS_ON,  FCS_ON,  0,   FCS_ON);
    tv[4]  = mk(MAC,         10,   -1,  0,  0,    0,  0,        1,       0,   0);
    tv[5]  = mk(MAC,         64,   -1,  0,  46,   1,  1,        0,       0,   0);
    tv[6]  = mk(MAC,         30,   -1,  1,  12,   1,  0,        1,       0,   1);
    tv[7]  = mk(MAC,         18,   -1,  0,  0,    1,  0,        1,       0,   0);
    tv[8]  = mk(MAC,         19,   -1,  0,  1,    1,  0,        1,       0,   1);
    tv[9]  = mk(MAC,         1518, -1,  0,  1500, 1,  1,        0,       0,   0);
    tv[10] = mk(MAC,         1600, -1,  0,  1500, 1,  0,        1,       0,   1);
    tv[11] = mk(C_BRDCST,    65,   -1,  0,  47,   1,  1,        0,       0,   0);

    ifc.rx_byte_vld = 1'b0;
    ifc.rx_data_vld = 1'b0;
    ifc.rx_byte     = 8'h00;
    exp_dst         = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outputs", all_outs(), 128'd0);

    for (int i = 0; i < 12; i++) run_vec(i);

    // Reset mid-payload: beats already emitted stand, then everything clears and the rest is ignored.
    build_frame(tv[0]);
    exp_dst = MAC;
    for (int k = 14; k <= 24; k++) sb_q.push_back({fb[k], 2'b00});
    b0 = cnt_bad; g0 = cnt_good;
    drive_bytes(0, 29, 0);
    @(negedge clk);
    ifc.rx_byte_vld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", all_outs(), 128'd0);
    chk("rst_mid_sb_empty", 128'(sb_q.size()), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_bytes(30, 63, 0);
    end_frame();
    chk("rst_mid_no_status", 128'((cnt_bad - b0) + (cnt_good - g0)), 128'd0);
    chk("rst_mid_hdr_cleared", 128'(ifc.dst_mac), 128'd0);

    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
